// File: rtl/mips_fetch_queue_if.sv
// Fetch-queue handshake bundle: imem request/response, redirect/halt, ID port.
// The master modport is the fetch queue; the slave side is memory plus ID/EX.
interface mips_fetch_queue_if #(
  parameter int AW = 10
);
  logic          imem_req_valid;
  logic [AW-1:0] imem_req_addr;
  logic          imem_req_ready;
  logic          imem_rsp_valid;
  logic [31:0]   imem_rsp_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          halt;
  logic          if_valid;
  logic [31:0]   if_ir;
  logic [31:0]   if_npc;
  logic          if_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc, halt,
    output if_valid, if_ir, if_npc,
    input  if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc, halt,
    input  if_valid, if_ir, if_npc,
    output if_ready
  );
endinterface

// File: rtl/mips_fetch_queue.sv
// MIPS32 fetch front end: credit-limited imem requests, in-order response FIFO.
// Optional stall/flush counters when MIPS_FETCHQ_STATS_EN is defined.
module mips_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 10
) (
  input logic clk1,
  input logic rst,
  mips_fetch_queue_if.master bus
`ifdef MIPS_FETCHQ_STATS_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] LIM = (CW+1)'(DEPTH);

  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_rsp_pc;
  logic [31:0]   r_ir [DEPTH];
  logic [AW-1:0] r_na [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_drop;

  logic          w_redir;
  logic          w_rsp;
  logic [CW:0]   w_used;
  logic          w_req;
  logic          w_fire;
  logic          w_iv;
  logic          w_pop;
  logic          w_push;
  logic [CW-1:0] w_out_left;

  assign w_redir = bus.redirect_valid;
  assign w_rsp   = bus.imem_rsp_valid;

  // queued entries plus in-flight requests never exceed DEPTH
  assign w_used = {1'b0, r_cnt} + {1'b0, r_out};
  assign w_req  = !rst && !bus.halt && !w_redir
                  && (w_used < LIM);
  assign w_fire = w_req && bus.imem_req_ready;

  assign w_iv   = !rst && !w_redir && (r_cnt != '0);
  assign w_pop  = w_iv && bus.if_ready;
  assign w_push = !w_redir && w_rsp
                  && (r_drop == '0);

  assign w_out_left = r_out - CW'(w_rsp);

  assign bus.imem_req_valid = w_req;
  assign bus.imem_req_addr  = r_pc;
  assign bus.if_valid       = w_iv;
  assign bus.if_ir  = w_iv ? r_ir[r_rd] : 32'h0;
  assign bus.if_npc = w_iv ? 32'(r_na[r_rd]) : 32'h0;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_pc     <= '0;
      r_rsp_pc <= '0;
      r_rd     <= '0;
      r_wr     <= '0;
      r_cnt    <= '0;
      r_out    <= '0;
      r_drop   <= '0;
    end else if (w_redir) begin
      // responses still owed to memory are discarded on arrival
      r_pc     <= bus.redirect_pc;
      r_rsp_pc <= bus.redirect_pc;
      r_rd     <= '0;
      r_wr     <= '0;
      r_cnt    <= '0;
      r_out    <= w_out_left;
      r_drop   <= w_out_left;
    end else begin
      if (w_fire)
        r_pc <= r_pc + AW'(1);
      r_out <= w_out_left + CW'(w_fire);
      if (w_rsp && (r_drop != '0))
        r_drop <= r_drop - CW'(1);
      if (w_push) begin
        r_rsp_pc <= r_rsp_pc + AW'(1);
        r_wr     <= r_wr + PW'(1);
      end
      if (w_pop)
        r_rd <= r_rd + PW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk1) begin
    if (w_push) begin
      r_ir[r_wr] <= bus.imem_rsp_data;
      r_na[r_wr] <= r_rsp_pc + AW'(1);
    end
  end

`ifdef MIPS_FETCHQ_STATS_EN
  logic [15:0] r_stall;
  logic [15:0] r_flush;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      if (!w_iv && !bus.halt && (r_stall != 16'hFFFF))
        r_stall <= r_stall + 16'd1;
      if (w_redir && (r_flush != 16'hFFFF))
        r_flush <= r_flush + 16'd1;
    end
  end

  assign stall_cnt = r_stall;
  assign flush_cnt = r_flush;
`endif
endmodule

// File: doc/mips_fetch_queue.md
# mips_fetch_queue

Instruction fetch front end for the pipelined MIPS32 core. Issues word-address requests to instruction memory through a valid/ready port, buffers in-order responses in a small FIFO, and presents instruction/next-PC pairs to the ID stage. Also handles branch redirects from the EX/MEM boundary, flushing queued and in-flight instructions, and stops issuing requests on halt.

## Interface
- DEPTH, 4: queue entries, power of two, 2..16; also the cap on requests in flight plus queued entries
- AW, 10: instruction word-address width (1024-word memory)
- clk1  in  1  sole clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  request pending
- imem_req_addr  out  AW  word address of request
- imem_req_ready  in  1  memory accepts request this cycle
- imem_rsp_valid  in  1  response data valid; in order, one per accepted request, latency ≥1 cycle
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  taken branch; flush and restart
- redirect_pc  in  AW  branch target word address
- halt  in  1  level; blocks new requests
- if_valid  out  1  head entry valid to ID
- if_ir  out  32  head instruction (0 when !if_valid)
- if_npc  out  32  zero-extended head address + 1 (0 when !if_valid)
- if_ready  in  1  ID consumes head this cycle

## Operation
- State: pc (next request address), rsp_pc (address of next kept response), FIFO of {ir, npc}, count, outstanding, drop.
- Issue: imem_req_valid = !rst && !halt && !redirect_valid && (count + outstanding < DEPTH). On valid && ready: pc <= pc+1, outstanding +1. imem_req_addr = pc. Address is held stable until accepted, except when withdrawn by redirect or halt.
- Response: on imem_rsp_valid, outstanding -1.
  - If drop != 0: discard the response, drop -1.
  - Otherwise push {imem_rsp_data, rsp_pc+1}, and rsp_pc +1.
  - Credit rule guarantees no push into a full FIFO.
- Pop: on if_valid && if_ready, remove the head entry.
- Push and pop in the same cycle are legal at any count. count is unchanged in that case.
- Redirect:
  - The FIFO is cleared next cycle: count <= 0.
  - pc <= redirect_pc; rsp_pc <= redirect_pc.
  - drop <= outstanding minus any response arriving that cycle. The arriving response is itself discarded.
  - if_valid is forced 0 in the redirect cycle, so no pop occurs.
  - Redirect takes priority over every other event.
- Redirect with drop already non-zero: the new drop value is computed from outstanding. It supersedes the old drop value because outstanding already includes those responses.
- Halt: no new requests. In-flight responses are still accepted. The queue still drains to ID.
- Address arithmetic wraps modulo 2^AW (pc = 2^AW−1 → next 0). if_npc carries the wrapped value, zero-extended.

## Timing
- Reset values: pc=0, rsp_pc=0, count=outstanding=drop=0, imem_req_valid=0, if_valid=0, if_ir=0, if_npc=0.
- imem_req_valid and if_valid are combinational from registered state plus halt/redirect_valid. if_ir and if_npc come directly from the FIFO head register.
- Response accepted in cycle N → if_valid high in cycle N+1 (one-cycle fill latency, no bypass).
- Redirect in cycle N:
  - First request to redirect_pc issues in cycle N+1 if credit allows.
  - The first kept instruction appears no earlier than response cycle + 1.
- Reset asserted mid-operation clears all state immediately. Responses to requests issued before reset are the memory's responsibility to suppress.
- Steady-state throughput with single-cycle memory and if_ready=1: one instruction per cycle.

## Configuration
- MIPS_FETCHQ_STATS_EN
  - Defined: adds outputs stall_cnt (16, out) and flush_cnt (16, out). Both reset to 0 and saturate at 16'hFFFF.
    - stall_cnt increments each cycle with !if_valid && !halt && !rst.
    - flush_cnt increments on each redirect_valid cycle.
  - Undefined: the ports and counters are absent and all other behaviour is identical.

## Test plan
- Reset, single-cycle memory returning Mem[a]=a+0x100, if_ready=1 → if_ir sequence 0x100, 0x101, 0x102… with if_npc 1, 2, 3…; first if_valid two cycles after reset release.
- if_ready=0 held → exactly DEPTH (4) entries queued, imem_req_valid low afterwards; release → four pops in order, then issue resumes.
- Three requests outstanding on 3-cycle-latency memory, redirect_pc=0x20 → three responses dropped; next if_ir = Mem[0x20], if_npc = 0x21; no stale instruction visible.
- Redirect in the same cycle as a response and a pending if_ready → response discarded, no pop, if_valid=0 that cycle, count=0 next cycle.
- halt asserted with two requests in flight → no new imem_req_valid, both instructions delivered, if_valid then stays 0.
- pc=0x3FF (AW=10) → following request address 0x000, if_npc of the 0x3FF entry = 0x000; with MIPS_FETCHQ_STATS_EN, flush_cnt=1 after one redirect.
